// File: rtl/vxc_row_fetch.sv
// vxc_row_fetch: fetches paired A/B rows from two row memories and presents them
// to a downstream consumer, with a one-row prefetch buffer that hides read latency.
// Ports: clk/reset (sync, active-high); start/total/base_a/base_b begin a pass;
//        mem_{a,b}_re/addr/rdata form the memory read interface (1-cycle latency);
//        read_again advances to the next row; first/second_row_fixed carry the
//        current A/B rows, qualified by row_valid; busy/done report pass status.
// Element i of a row occupies bits [i*ELEMENT_WIDTH +: ELEMENT_WIDTH].

module vxc_row_fetch #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int NO_OF_UNITS   = 8,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [31:0]                          total,
    input  logic [ADDR_WIDTH-1:0]                base_a,
    input  logic [ADDR_WIDTH-1:0]                base_b,
    output logic                                 mem_a_re,
    output logic                                 mem_b_re,
    output logic [ADDR_WIDTH-1:0]                mem_a_addr,
    output logic [ADDR_WIDTH-1:0]                mem_b_addr,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_a_rdata,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_b_rdata,
    input  logic                                 read_again,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_fixed,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_fixed,
    output logic                                 row_valid,
    output logic                                 busy,
    output logic                                 done
);

    localparam int          ROW_W = ELEMENT_WIDTH * NO_OF_UNITS;
    localparam logic [31:0] UNITS = 32'(NO_OF_UNITS);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PRESENT,
        DONE
    } state_t;

    state_t                  state;
    logic [31:0]             rows_q;      // rows in the current pass
    logic [31:0]             rem_q;       // live elements in the final row (0 = full row)
    logic [ADDR_WIDTH-1:0]   base_a_q;
    logic [ADDR_WIDTH-1:0]   base_b_q;
    logic [31:0]             fetch_idx;   // next row index to read
    logic [31:0]             rd_idx;      // row index of the read currently in flight
    logic [31:0]             pres_idx;    // row index on (or due on) the outputs
    logic                    cap_now;     // memory data for rd_idx is on rdata this cycle
    logic                    pf_vld;
    logic [ROW_W-1:0]        pf_a;
    logic [ROW_W-1:0]        pf_b;

    logic [31:0]             rows_calc;
    logic [ROW_W-1:0]        cap_a;
    logic [ROW_W-1:0]        cap_b;
    logic                    ra_acc;
    logic                    last_row;
    logic                    can_issue;

    // Zero the elements past the end of the vector when the final row is partial.
    function automatic logic [ROW_W-1:0] mask_row(input logic [ROW_W-1:0] row,
                                                  input logic [31:0]      idx,
                                                  input logic [31:0]      rows,
                                                  input logic [31:0]      rem);
        logic [ROW_W-1:0] r;
        r = row;
        if ((idx == rows - 32'd1) && (rem != 32'd0)) begin
            for (int i = 0; i < NO_OF_UNITS; i++) begin
                if (32'(i) >= rem) begin
                    r[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = '0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        rows_calc = (total / UNITS) + {31'd0, ((total % UNITS) != 32'd0)};
        cap_a     = mask_row(mem_a_rdata, rd_idx, rows_q, rem_q);
        cap_b     = mask_row(mem_b_rdata, rd_idx, rows_q, rem_q);
        ra_acc    = read_again && row_valid;
        last_row  = (pres_idx == rows_q - 32'd1);
        // One read outstanding: wait until the previous read has landed and the
        // prefetch slot is free before issuing the next.
        can_issue = (fetch_idx < rows_q) && !pf_vld && !mem_a_re && !cap_now;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            rows_q           <= '0;
            rem_q            <= '0;
            base_a_q         <= '0;
            base_b_q         <= '0;
            fetch_idx        <= '0;
            rd_idx           <= '0;
            pres_idx         <= '0;
            cap_now          <= 1'b0;
            pf_vld           <= 1'b0;
            pf_a             <= '0;
            pf_b             <= '0;
            mem_a_re         <= 1'b0;
            mem_b_re         <= 1'b0;
            mem_a_addr       <= '0;
            mem_b_addr       <= '0;
            first_row_fixed  <= '0;
            second_row_fixed <= '0;
            row_valid        <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            // Read enables are single-cycle pulses; data follows one cycle later.
            mem_a_re <= 1'b0;
            mem_b_re <= 1'b0;
            cap_now  <= mem_a_re;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        base_a_q  <= base_a;
                        base_b_q  <= base_b;
                        rows_q    <= rows_calc;
                        rem_q     <= total % UNITS;
                        pres_idx  <= '0;
                        pf_vld    <= 1'b0;
                        row_valid <= 1'b0;
                        if (total == 32'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state      <= ISSUE;
                            mem_a_re   <= 1'b1;
                            mem_b_re   <= 1'b1;
                            mem_a_addr <= base_a;
                            mem_b_addr <= base_b;
                            rd_idx     <= '0;
                            fetch_idx  <= 32'd1;
                        end
                    end
                end

                ISSUE: begin
                    state <= CAPTURE;
                end

                CAPTURE: begin
                    first_row_fixed  <= cap_a;
                    second_row_fixed <= cap_b;
                    row_valid        <= 1'b1;
                    state            <= PRESENT;
                end

                PRESENT: begin
                    if (ra_acc && last_row) begin
                        row_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (ra_acc) begin
                        pres_idx <= pres_idx + 32'd1;
                        if (pf_vld) begin
                            first_row_fixed  <= pf_a;
                            second_row_fixed <= pf_b;
                            pf_vld           <= 1'b0;
                        end else if (cap_now) begin
                            // Next row lands on this very edge: forward it straight out.
                            first_row_fixed  <= cap_a;
                            second_row_fixed <= cap_b;
                        end else begin
                            row_valid <= 1'b0;
                        end
                    end else if (cap_now) begin
                        if (row_valid) begin
                            pf_a   <= cap_a;
                            pf_b   <= cap_b;
                            pf_vld <= 1'b1;
                        end else begin
                            // Consumer already moved on; this row goes directly out.
                            first_row_fixed  <= cap_a;
                            second_row_fixed <= cap_b;
                            row_valid        <= 1'b1;
                        end
                    end

                    if (can_issue) begin
                        mem_a_re   <= 1'b1;
                        mem_b_re   <= 1'b1;
                        mem_a_addr <= base_a_q + fetch_idx[ADDR_WIDTH-1:0];
                        mem_b_addr <= base_b_q + fetch_idx[ADDR_WIDTH-1:0];
                        rd_idx     <= fetch_idx;
                        fetch_idx  <= fetch_idx + 32'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
